mcpu_alu_mp_driver: RTL and testbench

Multi-precision command driver for the MCPU ALU, i.e. the requester side of the ALU opcode/r1/r2 → out/OVERFLOW interface.
- Accepts one NWORDS×WORD_SIZE operation, slices it into WORD_SIZE chunks and issues them to an external MCPU_Alu instance, least significant word first.
- For ADD, propagates carry between words; collects the full-width result and raises a one-cycle done pulse.
- Sits between the MCPU control path and the single-word ALU.

---
 rtl/mcpu_alu_pkg.sv | 22 ++
 rtl/mcpu_word_slice.sv | 24 ++
 rtl/mcpu_alu_mp_driver.sv | 151 +++++++++++++++
 tb/tb_mcpu_alu_mp_driver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_alu_pkg.sv
// rtl/mcpu_alu_pkg.sv - opcodes, FSM states and index-width helper for the multi-precision ALU driver
package mcpu_alu_pkg;

  localparam int OP_AND = 0;
  localparam int OP_OR  = 1;
  localparam int OP_XOR = 2;
  localparam int OP_ADD = 3;

  // RUN is the one-cycle-per-word state; ISSUE/CAPTURE replace it when the ALU drive is registered
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int idx_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/mcpu_word_slice.sv
// rtl/mcpu_word_slice.sv - selects word idx of both operands and writes a word idx into the result vector
module mcpu_word_slice #(
  parameter int WORD_SIZE = 8,
  parameter int NWORDS    = 4,
  parameter int IDXW      = 2
) (
  input  logic [WORD_SIZE*NWORDS-1:0] src_a,
  input  logic [WORD_SIZE*NWORDS-1:0] src_b,
  input  logic [IDXW-1:0]             idx,
  input  logic [WORD_SIZE*NWORDS-1:0] res_in,
  input  logic [WORD_SIZE-1:0]        res_word,
  output logic [WORD_SIZE-1:0]        word_a,
  output logic [WORD_SIZE-1:0]        word_b,
  output logic [WORD_SIZE*NWORDS-1:0] res_out
);

  always_comb begin
    word_a  = src_a[int'(idx)*WORD_SIZE +: WORD_SIZE];
    word_b  = src_b[int'(idx)*WORD_SIZE +: WORD_SIZE];
    res_out = res_in;
    res_out[int'(idx)*WORD_SIZE +: WORD_SIZE] = res_word;
  end

endmodule

// File: rtl/mcpu_alu_mp_driver.sv
// rtl/mcpu_alu_mp_driver.sv - slices an NWORDS-wide op into single-word ALU requests, LS word first
// ALU_REG_EN: register the ALU drive, two cycles (ISSUE, CAPTURE) per word.
module mcpu_alu_mp_driver #(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 8,
  parameter int NWORDS    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CMD_SIZE-1:0]         opcode,
  input  logic [WORD_SIZE*NWORDS-1:0] a,
  input  logic [WORD_SIZE*NWORDS-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [WORD_SIZE*NWORDS-1:0] result,
  output logic                        carry_out,
  output logic                        result_zero,
  output logic [CMD_SIZE-1:0]         alu_opcode,
  output logic [WORD_SIZE-1:0]        alu_r1,
  output logic [WORD_SIZE-1:0]        alu_r2,
  input  logic [2*WORD_SIZE-1:0]      alu_out,
  input  logic                        alu_overflow
);
  import mcpu_alu_pkg::*;

  localparam int W    = WORD_SIZE * NWORDS;
  localparam int IDXW = idx_width(NWORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);
`ifdef ALU_REG_EN
  localparam state_e ST_WORD = ST_ISSUE;
`else
  localparam state_e ST_WORD = ST_RUN;
`endif

  state_e              state_q, state_d;
  logic [CMD_SIZE-1:0] op_q, op_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d, result_q, result_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d, carry_out_q, carry_out_d, zero_q, zero_d;
  logic [WORD_SIZE:0]  sum_w;
  logic [WORD_SIZE-1:0] cap_word, word_a, word_b;
  logic [W-1:0]        ins_out;
  logic                is_add;

  // Only the low WORD_SIZE+1 bits of alu_out carry information; ADD carry comes from bit WORD_SIZE
  logic unused_alu;
  assign unused_alu = &{1'b0, alu_overflow, alu_out[2*WORD_SIZE-1:WORD_SIZE+1]};

  mcpu_word_slice #(.WORD_SIZE(WORD_SIZE), .NWORDS(NWORDS), .IDXW(IDXW)) u_slice (
    .src_a(a_q), .src_b(b_q), .idx(idx_q), .res_in(result_q), .res_word(cap_word),
    .word_a(word_a), .word_b(word_b), .res_out(ins_out)
  );

  always_comb begin
    is_add   = (op_q == CMD_SIZE'(OP_ADD));
    sum_w    = alu_out[WORD_SIZE:0] + {{WORD_SIZE{1'b0}}, carry_q};
    cap_word = is_add ? sum_w[WORD_SIZE-1:0] : alu_out[WORD_SIZE-1:0];
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    case (state_q)
      ST_IDLE: if (start) begin
        op_d    = opcode;
        a_d     = a;
        b_d     = b;
        idx_d   = '0;
        carry_d = 1'b0;
        state_d = ST_WORD;
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_RUN, ST_CAPTURE: begin
        result_d = ins_out;
        carry_d  = is_add & sum_w[WORD_SIZE];
        if (idx_q == LAST_IDX) begin
          carry_out_d = is_add & sum_w[WORD_SIZE];
          zero_d      = (ins_out == '0);
          state_d     = ST_DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = ST_WORD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
    end
  end

`ifdef ALU_REG_EN
  logic [CMD_SIZE-1:0]  alu_op_q;
  logic [WORD_SIZE-1:0] alu_r1_q, alu_r2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_op_q <= '0;
      alu_r1_q <= '0;
      alu_r2_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      alu_op_q <= op_q;
      alu_r1_q <= word_a;
      alu_r2_q <= word_b;
    end
  end

  assign alu_opcode = alu_op_q;
  assign alu_r1     = alu_r1_q;
  assign alu_r2     = alu_r2_q;
`else
  // Latched operands and idx hold outside RUN, so the drive keeps its last value for free
  assign alu_opcode = op_q;
  assign alu_r1     = word_a;
  assign alu_r2     = word_b;
`endif

  assign busy        = (state_q == ST_RUN) || (state_q == ST_ISSUE) || (state_q == ST_CAPTURE);
  assign done        = (state_q == ST_DONE);
  assign result      = result_q;
  assign carry_out   = carry_out_q;
  assign result_zero = zero_q;

endmodule

// File: tb/tb_mcpu_alu_mp_driver.sv
// tb/tb_mcpu_alu_mp_driver.sv - directed bench with cycle model and single-word ALU model
module tb_mcpu_alu_mp_driver;

  localparam int N  = 4;
  localparam int WS = 8;
  localparam int W  = 32;
`ifdef ALU_REG_EN
  localparam int DONE_CYC = 2 * N;
  localparam int STRIDE   = 2;
  localparam int OFFS     = 1;
  localparam int EXP_LAT  = 9;
`else
  localparam int DONE_CYC = N;
  localparam int STRIDE   = 1;
  localparam int OFFS     = 0;
  localparam int EXP_LAT  = 5;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    opcode = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done, carry_out, result_zero, alu_overflow;
  logic [W-1:0]  result;
  logic [1:0]    alu_opcode;
  logic [WS-1:0] alu_r1, alu_r2;
  logic [2*WS-1:0] alu_out;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  logic [7:0] seq_r1[$];
  logic [7:0] seq_r2[$];

  always #5 clk = ~clk;

  mcpu_alu_mp_driver #(.CMD_SIZE(2), .WORD_SIZE(WS), .NWORDS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .result_zero(result_zero), .alu_opcode(alu_opcode), .alu_r1(alu_r1),
    .alu_r2(alu_r2), .alu_out(alu_out), .alu_overflow(alu_overflow)
  );

  // Single-word ALU the driver talks to
  always_comb begin
    case (alu_opcode)
      2'd0:    alu_out = {8'h00, alu_r1 & alu_r2};
      2'd1:    alu_out = {8'h00, alu_r1 | alu_r2};
      2'd2:    alu_out = {8'h00, alu_r1 ^ alu_r2};
      default: alu_out = {7'h00, {1'b0, alu_r1} + {1'b0, alu_r2}};
    endcase
    alu_overflow = (alu_opcode == 2'd3) && alu_out[WS];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op occupies DONE_CYC busy cycles then one done cycle
  bit           m_active = 0;
  int           m_cyc = 0;
  logic [1:0]   m_op;
  logic [W-1:0] m_a, m_b, m_fin, m_res = '0;
  logic         m_cfin, m_cout = 1'b0, m_zero = 1'b1;
  logic [1:0]   m_dop = '0;
  logic [7:0]   m_dr1 = '0, m_dr2 = '0;

  function automatic logic [7:0] wsel(input logic [W-1:0] v, input int i);
    logic [W-1:0] t;
    t = v >> (8 * i);
    return t[7:0];
  endfunction

  always @(posedge clk) begin
    int w;
    if (reset) begin
      m_active = 0; m_cyc = 0; m_res = '0; m_cout = 1'b0; m_zero = 1'b1;
      m_dop = '0; m_dr1 = '0; m_dr2 = '0;
    end else begin
      if (m_active) begin
        if (m_cyc == DONE_CYC) m_active = 0;
        else m_cyc++;
      end else if (start) begin
        m_active = 1; m_cyc = 0; m_op = opcode; m_a = a; m_b = b; m_cfin = 1'b0;
        case (opcode)
          2'd0: m_fin = a & b;
          2'd1: m_fin = a | b;
          2'd2: m_fin = a ^ b;
          default: {m_cfin, m_fin} = {1'b0, a} + {1'b0, b};
        endcase
      end
      if (m_active) begin
        if (m_cyc == DONE_CYC) begin
          m_res = m_fin; m_cout = m_cfin; m_zero = (m_fin == '0);
        end
        w = -1;
        if (m_cyc >= OFFS && m_cyc < DONE_CYC) w = (m_cyc - OFFS) / STRIDE;
        if (w >= 0) begin
          m_dop = m_op; m_dr1 = wsel(m_a, w); m_dr2 = wsel(m_b, w);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic eb, ed;
    eb = m_active && (m_cyc < DONE_CYC);
    ed = m_active && (m_cyc == DONE_CYC);
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("alu_opcode", alu_opcode, m_dop);
    chk("alu_r1", alu_r1, m_dr1);
    chk("alu_r2", alu_r2, m_dr2);
    if (!eb) begin
      chk("result", result, m_res);
      chk("carry_out", carry_out, m_cout);
      chk("result_zero", result_zero, m_zero);
    end
    if (done) done_count++;
    if (busy) begin
      seq_r1.push_back(alu_r1);
      seq_r2.push_back(alu_r2);
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] er, input logic ec, input logic ez, input string nm);
    int n;
    @(posedge clk); #1;
    start = 1'b1; opcode = op; a = va; b = vb;
    seq_r1.delete(); seq_r2.delete();
    @(posedge clk); #1;
    start = 1'b0; opcode = 2'($urandom); a = $urandom; b = $urandom;
    n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, n + 1, EXP_LAT);
    chk({nm, " result"}, result, er);
    chk({nm, " carry"}, carry_out, ec);
    chk({nm, " zero"}, result_zero, ez);
  endtask

  task automatic chk_seq(input string nm);
    logic [31:0] r1_lit, r2_lit;
    r1_lit = 32'hF0F01234;
    r2_lit = 32'hFF00FF00;
    for (int i = 0; i < N; i++) begin
      if (seq_r1.size() > OFFS + STRIDE * i) begin
        chk({nm, " seq r1"}, seq_r1[OFFS + STRIDE * i], r1_lit[8*i +: 8]);
        chk({nm, " seq r2"}, seq_r2[OFFS + STRIDE * i], r2_lit[8*i +: 8]);
      end else begin
        chk({nm, " seq length"}, seq_r1.size(), OFFS + STRIDE * i + 1);
      end
    end
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset result", result, 0);
    chk("reset zero", result_zero, 1);
    chk("reset alu_r1", alu_r1, 0);
    reset = 1'b0;

    run_op(2'd3, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, "add_ff");
    run_op(2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, "add_wrap");
    run_op(2'd0, 32'hF0F01234, 32'hFF00FF00, 32'hF0001200, 1'b0, 1'b0, "and");
    chk_seq("and");
    run_op(2'd1, 32'hF0F01234, 32'hFF00FF00, 32'hFFF0FF34, 1'b0, 1'b0, "or");
    chk_seq("or");
    run_op(2'd2, 32'hF0F01234, 32'hFF00FF00, 32'h0FF0ED34, 1'b0, 1'b0, "xor");
    chk_seq("xor");

    // start held high through RUN and DONE while operands wander
    @(posedge clk); #1;
    start = 1'b1; opcode = 2'd3; a = 32'h11112222; b = 32'h0000EEEE;
    @(posedge clk); #1;
    base = done_count;
    repeat (DONE_CYC + 1) begin
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("hold done pulses", done_count - base, 1);
    chk("hold result", result, 32'h11121110);
    chk("hold busy", busy, 0);
    run_op(2'd3, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, "after_hold");

    // reset during the second RUN cycle
    @(posedge clk); #1;
    start = 1'b1; opcode = 2'd3; a = 32'h0000FFFF; b = 32'h00000001;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst zero", result_zero, 1);
    base = done_count;
    repeat (2 * N + 4) @(posedge clk);
    #1;
    chk("rst no done", done_count - base, 0);
    run_op(2'd3, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, "add_after_rst");

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
